// File: rtl/unidad_aritmetica_pkg.sv
// Shared definitions for the arithmetic-unit arbiter.
// Contents:
//   OP_* op-select encodings understood by the arithmetic unit
//   estado_t arbiter FSM states
//   latencia() number of EXEC cycles granted to an op select
package unidad_aritmetica_pkg;

    localparam logic [3:0] OP_SUMA  = 4'd0;
    localparam logic [3:0] OP_RESTA = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } estado_t;

    // Unsupported selects get a single EXEC cycle, like add/sub.
    function automatic int unsigned latencia(input logic [3:0] s,
                                             input int unsigned mult_cycles,
                                             input int unsigned div_cycles);
        case (s)
            OP_MULT:        return mult_cycles;
            OP_DIV, OP_MOD: return div_cycles;
            default:        return 1;
        endcase
    endfunction

endpackage

// File: rtl/arbitro_unidad_aritmetica_if.sv
// Bus bundle between two requesters, the arbiter, the arithmetic unit and
// the result consumer.
// Signals:
//   req0_* / req1_*  valid/ready handshake plus A/B operands and S op select
//   alu_*            operands/op towards the unit, result and NZCV flags back
//   resp_*           registered result, flags, requester id and error flag
// Modports:
//   slave   arbiter view
//   master  environment view (requesters, unit, consumer)
interface arbitro_unidad_aritmetica_if #(
    parameter int NUM_BITS = 2
);
    logic                req0_valid;
    logic                req0_ready;
    logic [NUM_BITS-1:0] req0_A;
    logic [NUM_BITS-1:0] req0_B;
    logic [3:0]          req0_S;

    logic                req1_valid;
    logic                req1_ready;
    logic [NUM_BITS-1:0] req1_A;
    logic [NUM_BITS-1:0] req1_B;
    logic [3:0]          req1_S;

    logic [NUM_BITS-1:0] alu_A;
    logic [NUM_BITS-1:0] alu_B;
    logic [3:0]          alu_S;
    logic [NUM_BITS-1:0] alu_R;
    logic                alu_N, alu_Z, alu_C, alu_V;

    logic                resp_valid;
    logic                resp_ready;
    logic [NUM_BITS-1:0] resp_R;
    logic                resp_N, resp_Z, resp_C, resp_V;
    logic                resp_id;
    logic                resp_err;

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_S,
        input  req1_valid, req1_A, req1_B, req1_S,
        input  alu_R, alu_N, alu_Z, alu_C, alu_V,
        input  resp_ready,
        output req0_ready, req1_ready,
        output alu_A, alu_B, alu_S,
        output resp_valid, resp_R, resp_N, resp_Z, resp_C, resp_V,
        output resp_id, resp_err
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_S,
        output req1_valid, req1_A, req1_B, req1_S,
        output alu_R, alu_N, alu_Z, alu_C, alu_V,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  alu_A, alu_B, alu_S,
        input  resp_valid, resp_R, resp_N, resp_Z, resp_C, resp_V,
        input  resp_id, resp_err
    );

endinterface

// File: rtl/arbitro_rr_2.sv
// Two-way round-robin grant generator.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req       request vector, bit i = requester i
//   advance   a grant was taken this cycle; move priority past the winner
//   grant     one-hot grant (all zero when nobody requests)
module arbitro_rr_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1.
    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After a grant the other requester becomes favoured, so serving
    // requester 0 moves the pointer to 1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/arbitro_unidad_aritmetica.sv
// Shares one combinational arithmetic unit between two requesters.
// Round-robin arbitration picks a requester in IDLE, its A/B/S are latched
// and held on the unit for a per-op number of EXEC cycles, then the unit's
// result and NZCV flags are registered and offered on resp_* until taken.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of the arbiter bus (requesters, unit, response)
module arbitro_unidad_aritmetica
    import unidad_aritmetica_pkg::*;
#(
    parameter int unsigned NUM_BITS    = 2,
    parameter int unsigned MULT_CYCLES = 2,
    parameter int unsigned DIV_CYCLES  = 4
) (
    input logic                         clk,
    input logic                         rst,
    arbitro_unidad_aritmetica_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    estado_t             state;
    estado_t             state_next;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          req_vec;
    logic [1:0]          grant;
    logic                accept;
    logic                ready0;
    logic                ready1;

    logic [NUM_BITS-1:0] sel_A;
    logic [NUM_BITS-1:0] sel_B;
    logic [3:0]          sel_S;

    logic [NUM_BITS-1:0] op_A;
    logic [NUM_BITS-1:0] op_B;
    logic [3:0]          op_S;
    logic                op_id;

    logic [NUM_BITS-1:0] res_R;
    logic                res_N, res_Z, res_C, res_V;
    logic                res_id;
    logic                res_err;

    assign req_vec = {bus.req1_valid, bus.req0_valid};

    arbitro_rr_2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (accept),
        .grant   (grant)
    );

    assign sel_A = grant[1] ? bus.req1_A : bus.req0_A;
    assign sel_B = grant[1] ? bus.req1_B : bus.req0_B;
    assign sel_S = grant[1] ? bus.req1_S : bus.req0_S;

    // Next state and readiness. Readiness exists only in IDLE, so the
    // cycle that leaves DONE can never accept a new request.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        case (state)
            IDLE: begin
                ready0 = grant[0];
                ready1 = grant[1];
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand latches, cycle budget and result registers. Operand
    // latches only change on a handshake, so the unit's inputs stay at the
    // last op in DONE/IDLE instead of dropping to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_A    <= '0;
            op_B    <= '0;
            op_S    <= '0;
            op_id   <= 1'b0;
            res_R   <= '0;
            res_N   <= 1'b0;
            res_Z   <= 1'b0;
            res_C   <= 1'b0;
            res_V   <= 1'b0;
            res_id  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_A  <= sel_A;
                        op_B  <= sel_B;
                        op_S  <= sel_S;
                        op_id <= grant[1];
                        cnt   <= CNT_W'(latencia(sel_S, MULT_CYCLES, DIV_CYCLES) - 1);
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        res_R   <= bus.alu_R;
                        res_N   <= bus.alu_N;
                        res_Z   <= bus.alu_Z;
                        res_C   <= bus.alu_C;
                        res_V   <= bus.alu_V;
                        res_id  <= op_id;
                        res_err <= (op_S > OP_MOD);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_A      = op_A;
    assign bus.alu_B      = op_B;
    assign bus.alu_S      = op_S;
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_R     = res_R;
    assign bus.resp_N     = res_N;
    assign bus.resp_Z     = res_Z;
    assign bus.resp_C     = res_C;
    assign bus.resp_V     = res_V;
    assign bus.resp_id    = res_id;
    assign bus.resp_err   = res_err;

endmodule
